// File: rtl/rf_pkg.sv
// Shared constants and helpers for the parametrised register file and its busy-bit scoreboard.
package rf_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;
   localparam int unsigned NRD_DEF   = 2;
   localparam int unsigned REG_ZERO  = 0;

   // Address width for a register count; a single bit is the floor.
   function automatic int unsigned rf_aw(input int unsigned nregs);
      return (nregs < 2) ? 1 : $clog2(nregs);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register write-pending bits: claim sets, clearing writeback retires, claim wins on collision.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter  int unsigned NREGS = NREGS_DEF,
   localparam int unsigned AW    = rf_aw(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             claim,
   input  logic [AW-1:0]    claim_addr,
   input  logic             clr,
   input  logic [AW-1:0]    clr_addr,
   output logic [NREGS-1:0] busy,
   output logic             claim_err,
   output logic             busy_any
);

   logic [NREGS-1:0] busy_nxt;
   logic             claim_hit;
   logic             retiring;
   logic             err_set;

   // A claim on a register that retires in the same cycle is not a double claim.
   always_comb begin
      busy_nxt  = busy;
      claim_hit = claim && (claim_addr != AW'(REG_ZERO));
      retiring  = clr && (clr_addr == claim_addr);
      err_set   = claim_hit && busy[claim_addr] && !retiring;
      if (clr) begin
         busy_nxt[clr_addr] = 1'b0;
      end
      if (claim_hit) begin
         busy_nxt[claim_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= '0;
         claim_err <= 1'b0;
         busy_any  <= 1'b0;
      end else begin
         busy     <= busy_nxt;
         busy_any <= |busy_nxt;
         if (err_set) begin
            claim_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file with optional write bypass, busy scoreboard and debug read port.
module regfile_sb
   import rf_pkg::*;
#(
   parameter  int unsigned XLEN   = XLEN_DEF,
   parameter  int unsigned NREGS  = NREGS_DEF,
   parameter  int unsigned NRD    = NRD_DEF,
   parameter  bit          BYPASS = 1'b1,
   localparam int unsigned AW     = rf_aw(NREGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   rs_addr,
   output logic [NRD*XLEN-1:0] rs_data,
   output logic [NRD-1:0]      rs_busy,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [XLEN-1:0]     wdata,
   input  logic                wclr,
   input  logic                claim,
   input  logic [AW-1:0]       claim_addr,
   output logic                claim_err,
   output logic                busy_any,
   input  logic [AW-1:0]       dbg_addr,
   output logic [XLEN-1:0]     dbg_data
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic             wr_hit;
   logic             clr_hit;
   logic [AW-1:0]    ra;

   assign wr_hit  = we && (waddr != AW'(REG_ZERO));
   assign clr_hit = we && wclr;

   // Register 0 is never written, so it holds its reset value of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_hit) begin
         regs[waddr] <= wdata;
      end
   end

   rf_scoreboard #(
      .NREGS (NREGS)
   ) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .claim      (claim),
      .claim_addr (claim_addr),
      .clr        (clr_hit),
      .clr_addr   (waddr),
      .busy       (busy),
      .claim_err  (claim_err),
      .busy_any   (busy_any)
   );

   // Read muxes; with bypass a same-cycle write and its busy retirement are forwarded.
   always_comb begin
      rs_data = '0;
      rs_busy = '0;
      ra      = '0;
      for (int k = 0; k < NRD; k++) begin
         ra = rs_addr[k*AW +: AW];
         rs_data[k*XLEN +: XLEN] = (BYPASS && wr_hit && (waddr == ra)) ? wdata : regs[ra];
         rs_busy[k] = busy[ra] && !(BYPASS && clr_hit && (waddr == ra));
      end
   end

   assign dbg_data = regs[dbg_addr];

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a built-in write-pending scoreboard, the successor to the fixed 2-read/1-write, 32×32 file in the RV32IM core. It adds configurable width, depth and read-port count, a true asynchronous reset, an optional same-cycle write-to-read bypass, and per-register busy bits so multi-cycle units (divider, multiplier, loads) can claim a destination and stall dependent readers. The fixed debug taps are replaced by one addressable debug read port. It sits between decode (read/claim) and writeback (write/clear).

## Interface
- XLEN, 32: data width in bits.
- NREGS, 32: number of architectural registers, power of two ≥ 2; AW = log2(NREGS).
- NRD, 2: number of read ports, 1..4.
- BYPASS, 1: 1 = a same-cycle write is visible on the read ports; 0 = reads return the stored value only.

- clk  in  1  core clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs_addr  in  NRD*AW  read addresses, port k at bits [k*AW +: AW].
- rs_data  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN].
- rs_busy  out  NRD  1 = port k's register has a pending write.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  XLEN  write data.
- wclr  in  1  qualifies `we`: this write retires a claim and clears the busy bit.
- claim  in  1  mark `claim_addr` busy.
- claim_addr  in  AW  register being claimed.
- claim_err  out  1  sticky: a claim hit a register that was already busy.
- busy_any  out  1  OR of all busy bits.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  stored value at `dbg_addr`; never bypassed.

## Operation
- Register 0 is hardwired to zero.
  - Writes to address 0 are dropped.
  - A claim of address 0 is ignored and never sets `claim_err`.
  - `rs_busy` for address 0 is always 0.
- Write: when `we` is high and `waddr` ≠ 0, `regs[waddr]` takes `wdata` at the edge.
- Read data: combinational.
  - With BYPASS=1, if `we` is high, `waddr` ≠ 0 and `waddr` = `rs_addr[k]`, then `rs_data[k]` = `wdata`.
  - Otherwise `rs_data[k]` = `regs[rs_addr[k]]`.
- Busy read: `rs_busy[k]` = `busy[rs_addr[k]]`.
  - With BYPASS=1, a clearing write to the same register in the same cycle (`we`, `wclr`, matching `waddr`) forces `rs_busy[k]` to 0.
- Claim: when `claim` is high and `claim_addr` ≠ 0, `busy[claim_addr]` is set at the edge.
  - If that bit was already set, `claim_err` goes to 1 and stays there until reset.
- Clear: when `we` and `wclr` are both high, `busy[waddr]` is cleared at the edge.
  - A write without `wclr` leaves the busy bits unchanged.
- Claim and clear of the same register in the same cycle:
  - Claim wins: the bit ends up set.
  - No `claim_err`, because the bit was retiring in that cycle.
- Claim and clear of different registers in the same cycle: both take effect.
- A clearing write to a register that is not busy is legal: data is written and the bit stays 0.

## Timing
- Write-to-read latency: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
- Claim-to-`rs_busy` latency: 1 cycle. A claim is never visible in the cycle it is made.
- `busy_any` is registered-state based: it reflects the busy bits after the last edge.
- Reset (asynchronous on `rst_n` low, released with clk running):
  - all registers are 0 and all busy bits are 0;
  - `claim_err` = 0, `busy_any` = 0;
  - `rs_data`, `dbg_data` = 0 and `rs_busy` = 0 for every address.
- Reset in the middle of an outstanding claim discards the claim. A writeback arriving after reset release is treated as a clearing write to a non-busy register.
- There are no handshakes. The caller must not issue `claim` on a register whose `rs_busy` it has just stalled on; doing so is flagged by `claim_err`, not prevented.

## Structure
- Shared package `rf_pkg`:
  - default XLEN/NREGS/NRD;
  - an AW function (clog2);
  - the register-0 index constant.
- Sub-module `rf_scoreboard`: owns the NREGS busy bits, claim/clear priority, `claim_err` and `busy_any`.
- The top level holds the storage array, read/bypass muxes and debug port.

## Test plan
- Reset, then drive `rs_addr` = 1,2 and `dbg_addr` = 31 -> all data 0, all busy 0, `claim_err` = 0.
- Write 0xDEADBEEF to x5 with `rs_addr[0]`=5 in the same cycle -> `rs_data[0]` = 0xDEADBEEF that cycle (BYPASS=1), or stored value that cycle and 0xDEADBEEF the next (BYPASS=0); `dbg_data` updates only after the edge.
- Write 0x1234 to x0, then read x0 -> 0; claim x0 -> `rs_busy` 0, `claim_err` 0.
- Claim x7; next cycle read x7 -> `rs_busy` 1, `busy_any` 1; clearing write of 42 -> same-cycle `rs_busy` 0 (BYPASS=1) with data 42; following cycle `busy_any` 0.
- Claim x9 twice on consecutive cycles -> `claim_err` rises after the second edge and stays 1. Same-cycle claim and clear of x9 -> x9 busy, no new error.
- NRD=3, XLEN=64, NREGS=16: random writes and reads against a reference model; assert `rst_n` low mid-claim -> busy bits and data cleared immediately, without waiting for a clock edge.
